// File: rtl/acc_job_ctrl_pkg.sv
// acc_job_ctrl_pkg: FSM state encoding and default widths shared by acc_job_ctrl and its counter
package acc_job_ctrl_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam int IN_DATA_WIDTH_D = 8;
    localparam int CNT_W_D         = 16;
    localparam int TIMEOUT_CYC_D   = 1024;
endpackage

// File: rtl/acc_job_cnt.sv
// acc_job_cnt: loadable down-counter tracking the beats still owed to the current job
//  clk, reset_n  clock, asynchronous active-low reset
//  load_i/val_i  load the beat count (wins over dec_i)
//  dec_i         one beat accepted
//  zero_o        no beats left
//  last_o        exactly one beat left
module acc_job_cnt
    import acc_job_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);
    logic [CNT_W-1:0] r_cnt;

    assign zero_o = (r_cnt == '0);
    assign last_o = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (load_i)
            r_cnt <= val_i;
        else if (dec_i && !zero_o)
            r_cnt <= r_cnt - CNT_W'(1);
    end
endmodule

// File: rtl/acc_job_ctrl.sv
// acc_job_ctrl: job sequencer feeding acc_core; reports each job's sum as end total minus start total
//  Optional feature: define ACC_JOB_CTRL_TIMEOUT_EN to end a stalled job after TIMEOUT_CYC idle RUN cycles.
//  clk, reset_n                 clock, asynchronous active-low reset
//  start_i, len_i, idle_o       job command (sampled only while idle_o)
//  in_valid_i/in_data_i/in_ready_o  operand stream
//  acc_run_o/acc_valid_o/acc_number_o/acc_result_i  acc_core interface
//  done_o, sum_o, err_o         job completion pulse, job sum, timeout flag
module acc_job_ctrl
    import acc_job_ctrl_pkg::*;
#(
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_D,
    parameter int DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int CNT_W         = CNT_W_D,
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_D
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [CNT_W-1:0]         len_i,
    output logic                     idle_o,
    input  logic                     in_valid_i,
    input  logic [IN_DATA_WIDTH-1:0] in_data_i,
    output logic                     in_ready_o,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o,
    input  logic [DWIDTH-1:0]        acc_result_i,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        sum_o,
    output logic                     err_o
);
    state_t            r_state, w_next;
    logic [DWIDTH-1:0] r_base, r_sum;
    logic              r_done;
    logic              w_beat, w_load, w_last, w_zero, w_timeout;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("acc_job_ctrl: TIMEOUT_CYC must be at least 2");
    end

    assign w_load       = (r_state == S_IDLE) && start_i;
    assign in_ready_o   = (r_state == S_RUN);
    assign w_beat       = in_valid_i && in_ready_o;
    assign idle_o       = (r_state == S_IDLE);
    assign acc_run_o    = (r_state == S_RUN);
    assign acc_valid_o  = w_beat;
    assign acc_number_o = in_data_i;
    assign done_o       = r_done;
    assign sum_o        = r_sum;

    acc_job_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (w_load),
        .val_i  (len_i),
        .dec_i  (w_beat),
        .zero_o (w_zero),
        .last_o (w_last)
    );

`ifdef ACC_JOB_CTRL_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC);
    logic [ST_W-1:0] r_stall;
    logic            r_err;

    assign w_timeout = (r_state == S_RUN) && !w_beat && (r_stall == ST_W'(TIMEOUT_CYC - 1));
    assign err_o     = r_err;

    // Held at zero outside RUN, so every RUN entry starts a fresh stall window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            r_stall <= (r_state != S_RUN || w_beat) ? '0 : r_stall + ST_W'(1);
            if (w_load)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // w_zero in RUN cannot occur in normal operation; it only guards against a stuck job.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start_i) w_next = (len_i == '0) ? S_DONE : S_RUN;
            S_RUN:   if ((w_beat && w_last) || w_zero || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // acc_core has no clear: the job sum is the modular difference of its running total.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_sum   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_DONE);
            if (w_load)
                r_base <= acc_result_i;
            if (r_state == S_DONE)
                r_sum <= acc_result_i - r_base;
        end
    end
endmodule

// File: tb/tb_acc_job_ctrl.sv
// tb_acc_job_ctrl: bench for acc_job_ctrl driving a behavioural acc_core, table jobs plus corner sequences
module tb_acc_job_ctrl;
    typedef struct {
        int         len;
        logic [7:0] d [8];
        bit         gaps;
        bit         pulse;
        int         exp_sum;
    } vec_t;
    typedef struct {
        logic [31:0] sum;
        logic        err;
    } exp_t;

    logic        clk = 0;
    logic        reset_n;
    logic        start_i, in_valid_i, idle_o, in_ready_o, acc_run, acc_valid, done_o, err_o;
    logic [15:0] len_i;
    logic [7:0]  in_data_i, acc_number;
    logic [31:0] acc_total, sum_o;

    logic        s_start, s_valid, s_idle, s_ready, s_run, s_avalid, s_done, s_err;
    logic [7:0]  s_len, s_total, s_sum;
    logic [1:0]  s_data, s_num;

    int   n_cmp = 0, n_bad = 0, cyc = 0, n_done = 0, done_cyc = 0, ns_done = 0;
    exp_t sb[$];
    logic [7:0] sb2[$];
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    acc_job_ctrl #(.IN_DATA_WIDTH(8), .DWIDTH(32), .CNT_W(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .len_i(len_i), .idle_o(idle_o),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .acc_run_o(acc_run), .acc_valid_o(acc_valid), .acc_number_o(acc_number),
        .acc_result_i(acc_total), .done_o(done_o), .sum_o(sum_o), .err_o(err_o)
    );

    acc_job_ctrl #(.IN_DATA_WIDTH(2), .DWIDTH(8), .CNT_W(8), .TIMEOUT_CYC(8)) dut_s (
        .clk(clk), .reset_n(reset_n), .start_i(s_start), .len_i(s_len), .idle_o(s_idle),
        .in_valid_i(s_valid), .in_data_i(s_data), .in_ready_o(s_ready),
        .acc_run_o(s_run), .acc_valid_o(s_avalid), .acc_number_o(s_num),
        .acc_result_i(s_total), .done_o(s_done), .sum_o(s_sum), .err_o(s_err)
    );

    // Behavioural acc_core: running total with no clear, sharing reset with the controller.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_total <= '0;
            s_total   <= '0;
        end else begin
            if (acc_run && acc_valid) acc_total <= acc_total + 32'(acc_number);
            if (s_run && s_avalid) s_total <= s_total + 8'(s_num);
        end
    end

    function automatic void check(string nm, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1 && done_o) begin
            exp_t e;
            n_done++;
            done_cyc = cyc;
            check("done_ready_overlap", in_ready_o, 0);
            check("idle_with_done", idle_o, 1);
            if (sb.size() == 0)
                check("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                check("sum", sum_o, e.sum);
                check("err", err_o, e.err);
            end
        end
        if (reset_n === 1'b1 && s_done) begin
            ns_done++;
            if (sb2.size() == 0)
                check("s_unexpected_done", 1, 0);
            else
                check("s_sum_wrap", s_sum, sb2.pop_front());
        end
    end

    task automatic start_job(input int len);
        start_i = 1;
        len_i   = 16'(len);
        @(posedge clk); #1;
        start_i = 0;
        len_i   = 16'hFFFF;
    endtask

    task automatic send(input logic [7:0] d, output int k);
        int g = 0;
        bit b;
        in_valid_i = 1;
        in_data_i  = d;
        do begin
            b = in_ready_o;
            @(posedge clk); #1;
            g++;
        end while (!b && g < 20);
        k = cyc;
        in_valid_i = 0;
        if (!b) check("send_accept", 0, 1);
    endtask

    task automatic wait_done(input int d0, input int lim, output bit got);
        int g = 0;
        while (n_done == d0 && g < lim) begin
            @(posedge clk); #1;
            g++;
        end
        got = (n_done != d0);
    endtask

    task automatic do_job(input vec_t v, input string nm);
        int  i = 0, g = 0, k, d0;
        bit  saw_rdy, b, got;
        while (!idle_o && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        sb.push_back('{32'(v.exp_sum), 1'b0});
        d0 = n_done;
        start_job(v.len);
        k = cyc;
        saw_rdy = 0;
        g = 0;
        while (i < v.len && g < 100) begin
            in_valid_i = !(v.gaps && g[0] == 1'b0);
            in_data_i  = in_valid_i ? v.d[i] : 8'hEE;
            start_i    = v.pulse && g == 1;
            len_i      = 16'd2;
            b = in_valid_i && in_ready_o;
            @(posedge clk); #1;
            if (b) begin
                i++;
                k = cyc;
            end
            g++;
        end
        in_valid_i = 0;
        start_i    = 0;
        g = 0;
        while (n_done == d0 && g < 20) begin
            if (in_ready_o) saw_rdy = 1;
            @(posedge clk); #1;
            g++;
        end
        got = (n_done != d0);
        if (!got) check({nm, "_done_seen"}, 0, 1);
        else check({nm, "_latency"}, done_cyc - k, 1);
        if (v.len == 0) check({nm, "_len0_ready"}, saw_rdy, 0);
    endtask

    task automatic s_job(input int len, input logic [1:0] first, input logic [1:0] rest, input logic [7:0] exp);
        int i = 0, g = 0, d0;
        bit b;
        d0 = ns_done;
        sb2.push_back(exp);
        s_start = 1;
        s_len   = 8'(len);
        @(posedge clk); #1;
        s_start = 0;
        while (i < len && g < 300) begin
            s_valid = 1;
            s_data  = (i == 0) ? first : rest;
            b = s_ready;
            @(posedge clk); #1;
            if (b) i++;
            g++;
        end
        s_valid = 0;
        g = 0;
        while (ns_done == d0 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("s_done_seen", ns_done - d0, 1);
    endtask

    initial begin
        int  k, d0;
        bit  got;
        vecs[0] = '{4, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 10};
        vecs[1] = '{3, '{8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 15};
        vecs[2] = '{0, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 0};
        vecs[3] = '{3, '{8'd9, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 1, 24};
        vecs[4] = '{5, '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, 0, 0, 1275};
        vecs[5] = '{1, '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 0, 42};

        reset_n = 0;
        start_i = 0; len_i = 0; in_valid_i = 1; in_data_i = 0;
        s_start = 0; s_len = 0; s_valid = 0; s_data = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle", idle_o, 1);
        check("rst_ready", in_ready_o, 0);
        check("rst_run", acc_run, 0);
        check("rst_valid", acc_valid, 0);
        check("rst_done", done_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_err", err_o, 0);
        in_valid_i = 0;
        reset_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) do_job(vecs[i], $sformatf("vec%0d", i));

`ifdef ACC_JOB_CTRL_TIMEOUT_EN
        sb.push_back('{32'd7, 1'b1});
        d0 = n_done;
        start_job(3);
        send(8'd7, k);
        wait_done(d0, 40, got);
        check("timeout_done", got, 1);
`else
        sb.push_back('{32'd13, 1'b0});
        d0 = n_done;
        start_job(2);
        send(8'd7, k);
        repeat (40) @(posedge clk);
        #1;
        check("stall_ready", in_ready_o, 1);
        check("stall_no_done", n_done, d0);
        send(8'd6, k);
        wait_done(d0, 10, got);
        check("stall_done", got, 1);
`endif
        do_job(vecs[0], "after_stall");

        s_job(84, 2'd1, 2'd3, 8'd250);
        s_job(3, 2'd3, 2'd3, 8'd9);

        d0 = n_done;
        start_job(3);
        send(8'd9, k);
        #3;
        reset_n = 0;
        #1;
        check("midrst_idle", idle_o, 1);
        check("midrst_ready", in_ready_o, 0);
        check("midrst_run", acc_run, 0);
        check("midrst_done", done_o, 0);
        check("midrst_sum", sum_o, 0);
        check("midrst_err", err_o, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_done", n_done, d0);
        do_job(vecs[1], "post_reset");

        check("sb_drain", sb.size(), 0);
        check("sb2_drain", sb2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
